sobel_window_feeder: RTL

- Upstream stage of the SobelFilter HLS block.
- Accepts a raster-order RGB pixel stream for one frame and keeps three rotating line buffers.
- For every pixel position it replays the 3x3 neighbourhood as 9 consecutive beats on a busy/vld channel that connects directly to SobelFilter's i_rgb_* port.
- Out-of-image neighbours are zero-padded.

---
 rtl/sobel_window_feeder.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/sobel_window_feeder.sv
// sobel_window_feeder: buffers a raster RGB frame in three rotating line
// buffers and replays every pixel's zero-padded 3x3 neighbourhood as nine
// consecutive beats on a busy/vld channel feeding SobelFilter.
module sobel_window_feeder #(
  parameter int unsigned IMG_W = 256,
  parameter int unsigned IMG_H = 256,
  parameter int unsigned PIX_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_pix_vld,
  input  logic [PIX_W-1:0] i_pix_data,
  output logic             i_pix_busy,
  input  logic             o_rgb_busy,
  output logic             o_rgb_vld,
  output logic [PIX_W-1:0] o_rgb_data,
  output logic             o_frame_done
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [1:0] {
    S_FILL0 = 2'd0,
    S_FILL1 = 2'd1,
    S_EMIT  = 2'd2,
    S_FILL  = 2'd3
  } state_t;

  // Modulo-3 add for the buffer-rotation pointer (operands are 0..2).
  function automatic logic [1:0] f_mod3_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Control state
  state_t           r_state, w_state_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic [1:0]       r_dx, w_dx_nxt;
  logic [1:0]       r_dy, w_dy_nxt;
  logic [ROW_W-1:0] r_cr, w_cr_nxt;
  logic [1:0]       r_ptr, w_ptr_nxt;
  logic             r_issue_done, w_issue_done_nxt;
  logic             r_pix_busy, w_pix_busy_nxt;
  logic             r_frame_done, w_frame_done_nxt;

  // Read pipeline: s1 = RAM read register, out = output register
  logic             r_s1_vld, r_s1_last;
  logic [PIX_W-1:0] r_s1_data;
  logic             r_out_vld, r_out_last;
  logic [PIX_W-1:0] r_out_data;

  logic [PIX_W-1:0] r_mem [3][IMG_W];

  logic             w_pix_acc, w_col_last;
  logic             w_adv, w_issue, w_last_issue, w_emit_end;
  logic             w_rd_pad;
  logic [1:0]       w_rd_buf, w_wr_buf;
  logic [COL_W-1:0] w_rd_col;

  assign w_col_last   = (r_col == COL_W'(IMG_W - 1));
  assign w_pix_acc    = i_pix_vld && !r_pix_busy && (r_state != S_EMIT);
  // Pipeline may move whenever the output register is empty or being drained.
  assign w_adv        = !r_out_vld || !o_rgb_busy;
  assign w_issue      = (r_state == S_EMIT) && !r_issue_done && w_adv;
  assign w_last_issue = (r_dx == 2'd2) && (r_dy == 2'd2) && w_col_last;
  assign w_emit_end   = r_out_vld && !o_rgb_busy && r_out_last;

  // Write target: row 0 -> ptr, row 1 -> ptr+1, later rows replace row cr-1.
  always_comb begin
    case (r_state)
      S_FILL0: w_wr_buf = r_ptr;
      S_FILL1: w_wr_buf = f_mod3_add(r_ptr, 2'd1);
      default: w_wr_buf = f_mod3_add(r_ptr, 2'd2);
    endcase
  end

  // Neighbour address and zero-pad decision for the beat being issued.
  always_comb begin
    w_rd_buf = f_mod3_add(r_ptr, f_mod3_add(r_dy, 2'd2));
    case (r_dx)
      2'd0:    w_rd_col = r_col - COL_W'(1);
      2'd1:    w_rd_col = r_col;
      default: w_rd_col = r_col + COL_W'(1);
    endcase
    w_rd_pad = ((r_dy == 2'd0) && (r_cr == '0)) ||
               ((r_dy == 2'd2) && (r_cr == ROW_W'(IMG_H - 1))) ||
               ((r_dx == 2'd0) && (r_col == '0)) ||
               ((r_dx == 2'd2) && w_col_last);
  end

  // Next-state and next-counter logic for fill/emit sequencing.
  always_comb begin
    w_state_nxt      = r_state;
    w_col_nxt        = r_col;
    w_dx_nxt         = r_dx;
    w_dy_nxt         = r_dy;
    w_cr_nxt         = r_cr;
    w_ptr_nxt        = r_ptr;
    w_issue_done_nxt = r_issue_done;
    w_pix_busy_nxt   = r_pix_busy;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      S_FILL0: begin
        if (w_pix_acc) begin
          if (w_col_last) begin
            w_col_nxt   = '0;
            w_state_nxt = S_FILL1;
          end else begin
            w_col_nxt = r_col + COL_W'(1);
          end
        end
      end
      S_FILL1, S_FILL: begin
        if (w_pix_acc) begin
          if (w_col_last) begin
            w_col_nxt      = '0;
            w_state_nxt    = S_EMIT;
            w_pix_busy_nxt = 1'b1;
            if (r_state == S_FILL) begin
              w_cr_nxt  = r_cr + ROW_W'(1);
              w_ptr_nxt = f_mod3_add(r_ptr, 2'd1);
            end
          end else begin
            w_col_nxt = r_col + COL_W'(1);
          end
        end
      end
      S_EMIT: begin
        if (w_issue) begin
          if (r_dx == 2'd2) begin
            w_dx_nxt = 2'd0;
            if (r_dy == 2'd2) begin
              w_dy_nxt = 2'd0;
              if (w_col_last) begin
                w_col_nxt        = '0;
                w_issue_done_nxt = 1'b1;
              end else begin
                w_col_nxt = r_col + COL_W'(1);
              end
            end else begin
              w_dy_nxt = r_dy + 2'd1;
            end
          end else begin
            w_dx_nxt = r_dx + 2'd1;
          end
        end
        if (w_emit_end) begin
          w_col_nxt        = '0;
          w_dx_nxt         = 2'd0;
          w_dy_nxt         = 2'd0;
          w_issue_done_nxt = 1'b0;
          if (r_cr == ROW_W'(IMG_H - 1)) begin
            w_frame_done_nxt = 1'b1;
            w_state_nxt      = S_FILL0;
            w_cr_nxt         = '0;
            w_ptr_nxt        = 2'd0;
            w_pix_busy_nxt   = 1'b0;
          end else if (r_cr == ROW_W'(IMG_H - 2)) begin
            w_cr_nxt  = r_cr + ROW_W'(1);
            w_ptr_nxt = f_mod3_add(r_ptr, 2'd1);
          end else begin
            w_state_nxt    = S_FILL;
            w_pix_busy_nxt = 1'b0;
          end
        end
      end
      default: w_state_nxt = S_FILL0;
    endcase
  end

  // Control register bank.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_FILL0;
      r_col        <= '0;
      r_dx         <= 2'd0;
      r_dy         <= 2'd0;
      r_cr         <= '0;
      r_ptr        <= 2'd0;
      r_issue_done <= 1'b0;
      r_pix_busy   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_col        <= w_col_nxt;
      r_dx         <= w_dx_nxt;
      r_dy         <= w_dy_nxt;
      r_cr         <= w_cr_nxt;
      r_ptr        <= w_ptr_nxt;
      r_issue_done <= w_issue_done_nxt;
      r_pix_busy   <= w_pix_busy_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Line-buffer write port and synchronous read port (contents never reset).
  always_ff @(posedge i_clk) begin
    if (w_pix_acc) r_mem[w_wr_buf][r_col] <= i_pix_data;
    if (w_issue) r_s1_data <= w_rd_pad ? '0 : r_mem[w_rd_buf][w_rd_col];
  end

  // Two-stage read pipeline; frozen while the output beat is stalled.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
    end else if (w_adv) begin
      r_out_vld  <= r_s1_vld;
      r_out_last <= r_s1_vld && r_s1_last;
      r_out_data <= r_s1_vld ? r_s1_data : '0;
      r_s1_vld   <= w_issue;
      r_s1_last  <= w_issue && w_last_issue;
    end
  end

  assign i_pix_busy   = r_pix_busy;
  assign o_rgb_vld    = r_out_vld;
  assign o_rgb_data   = r_out_data;
  assign o_frame_done = r_frame_done;

endmodule
